// File: rtl/lcd1602_pkg.sv
// Shared LCD1602 definitions: FSM states, strobe phases,
// default HD44780 timing at 50 MHz and command codes.
package lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENH,
    ST_HOLD,
    ST_CHECK,
    ST_DONE,
    ST_RELEASE
  } st_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_HIGH,
    PH_HOLD
  } ph_e;

  localparam int T_SETUP_DEF   = 2;
  localparam int T_ENH_DEF     = 25;
  localparam int T_DSAMPLE_DEF = 20;
  localparam int T_HOLD_DEF    = 23;
  localparam int MAX_POLLS_DEF = 1000;

  localparam int BF_BIT = 7;

  localparam logic RS_STATUS = 1'b0;
  localparam logic RS_DATA   = 1'b1;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_FUNC_8B = 8'h38;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd1602_rdfuncmod_if.sv
// Request/response bundle between the display
// control FSM and the LCD1602 read function block.
interface lcd1602_rdfuncmod_if;
  logic       iCall;
  logic       iMode;
  logic       iRS;
  logic       oDone;
  logic [7:0] oData;
  logic       oTimeout;

  modport master (
    output iCall, iMode, iRS,
    input  oDone, oData, oTimeout
  );

  modport slave (
    input  iCall, iMode, iRS,
    output oDone, oData, oTimeout
  );
endinterface

// File: rtl/lcd1602_strobe.sv
// HD44780 EN strobe: setup, high and hold phases with
// a mid-high sample pulse; shared by reader and writer.
module lcd1602_strobe
  import lcd1602_pkg::*;
#(
  parameter int T_SETUP   = T_SETUP_DEF,
  parameter int T_ENH     = T_ENH_DEF,
  parameter int T_DSAMPLE = T_DSAMPLE_DEF,
  parameter int T_HOLD    = T_HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic en,
  output logic sample,
  output logic setup_end,
  output logic high_end,
  output logic cycle_end
);

  localparam int CW =
    $clog2(max3(T_SETUP, T_ENH, T_HOLD)) + 1;

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_SET = CW'(T_SETUP);
  localparam logic [CW-1:0] C_ENH = CW'(T_ENH);
  localparam logic [CW-1:0] C_SMP = CW'(T_DSAMPLE);
  localparam logic [CW-1:0] C_HLD = CW'(T_HOLD);

  ph_e           ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;

  always_comb begin
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    setup_end = (ph_q == PH_SETUP) && (cnt_q == C_SET);
    high_end  = (ph_q == PH_HIGH) && (cnt_q == C_ENH);
    cycle_end = (ph_q == PH_HOLD) && (cnt_q == C_HLD);
    sample    = (ph_q == PH_HIGH) && (cnt_q == C_SMP);
    if (abort) begin
      ph_d  = PH_IDLE;
      cnt_d = '0;
      en_d  = 1'b0;
    end else if (start) begin
      ph_d  = PH_SETUP;
      cnt_d = C_ONE;
      en_d  = 1'b0;
    end else begin
      unique case (1'b1)
        setup_end: begin
          ph_d  = PH_HIGH;
          cnt_d = C_ONE;
          en_d  = 1'b1;
        end
        high_end: begin
          ph_d  = PH_HOLD;
          cnt_d = C_ONE;
          en_d  = 1'b0;
        end
        cycle_end: begin
          ph_d  = PH_IDLE;
          cnt_d = '0;
        end
        default: begin
          if (ph_q != PH_IDLE) cnt_d = cnt_q + C_ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q  <= PH_IDLE;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign en = en_q;

endmodule

// File: rtl/lcd1602_rdfuncmod.sv
// LCD1602 read function: status/data-RAM reads with
// optional busy-flag polling and poll timeout.
module lcd1602_rdfuncmod
  import lcd1602_pkg::*;
#(
  parameter int T_SETUP   = T_SETUP_DEF,
  parameter int T_ENH     = T_ENH_DEF,
  parameter int T_DSAMPLE = T_DSAMPLE_DEF,
  parameter int T_HOLD    = T_HOLD_DEF,
  parameter int MAX_POLLS = MAX_POLLS_DEF
) (
  input  logic                CLOCK,
  input  logic                RST_n,
  lcd1602_rdfuncmod_if.slave  bus,
  output logic                LCD1602_RS,
  output logic                LCD1602_RW,
  output logic                LCD1602_EN,
  inout  wire  [7:0]          LCD1602_D
);

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam logic [PW-1:0] P_MAX = PW'(MAX_POLLS);
  localparam logic [PW-1:0] P_ONE = PW'(1);

  st_e           st_q, st_d;
  logic          rs_q, rs_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] polls_q, polls_d;
  logic [7:0]    data_q, data_d;
  logic          to_q, to_d;
  logic          done_q, done_d;

  logic start, abort, busy, bf_wait;
  logic en, sample, setup_end, high_end, cycle_end;

  lcd1602_strobe #(
    .T_SETUP   (T_SETUP),
    .T_ENH     (T_ENH),
    .T_DSAMPLE (T_DSAMPLE),
    .T_HOLD    (T_HOLD)
  ) u_strobe (
    .clk       (CLOCK),
    .rst_n     (RST_n),
    .start     (start),
    .abort     (abort),
    .en        (en),
    .sample    (sample),
    .setup_end (setup_end),
    .high_end  (high_end),
    .cycle_end (cycle_end)
  );

  always_comb begin
    st_d    = st_q;
    rs_d    = rs_q;
    mode_d  = mode_q;
    polls_d = polls_q;
    data_d  = data_q;
    to_d    = to_q;
    done_d  = (st_q == ST_DONE);
    start   = 1'b0;
    abort   = 1'b0;
    busy    = (st_q == ST_SETUP) || (st_q == ST_ENH) ||
              (st_q == ST_HOLD) || (st_q == ST_CHECK);
    bf_wait = mode_q && (rs_q == RS_STATUS) &&
              data_q[BF_BIT];
    if (sample) data_d = LCD1602_D;
    if (cycle_end && (polls_q < P_MAX))
      polls_d = polls_q + P_ONE;
    if (busy && !bus.iCall) begin
      abort   = 1'b1;
      st_d    = ST_IDLE;
      polls_d = '0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (bus.iCall) begin
            st_d    = ST_SETUP;
            rs_d    = bus.iRS;
            mode_d  = bus.iMode;
            to_d    = 1'b0;
            polls_d = '0;
            start   = 1'b1;
          end
        end
        ST_SETUP: if (setup_end) st_d = ST_ENH;
        ST_ENH:   if (high_end)  st_d = ST_HOLD;
        ST_HOLD:  if (cycle_end) st_d = ST_CHECK;
        ST_CHECK: begin
          // bf_wait here with polls at the cap means timeout
          if (bf_wait && (polls_q < P_MAX)) begin
            st_d  = ST_SETUP;
            start = 1'b1;
          end else begin
            st_d = ST_DONE;
            to_d = bf_wait;
          end
        end
        ST_DONE:    st_d = ST_RELEASE;
        ST_RELEASE: if (!bus.iCall) st_d = ST_IDLE;
        default:    st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      st_q    <= ST_IDLE;
      rs_q    <= RS_STATUS;
      mode_q  <= 1'b0;
      polls_q <= '0;
      data_q  <= 8'h00;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      rs_q    <= rs_d;
      mode_q  <= mode_d;
      polls_q <= polls_d;
      data_q  <= data_d;
      to_q    <= to_d;
      done_q  <= done_d;
    end
  end

  assign LCD1602_RS   = rs_q;
  assign LCD1602_RW   = 1'b1;
  assign LCD1602_EN   = en;
  assign bus.oDone    = done_q;
  assign bus.oData    = data_q;
  assign bus.oTimeout = to_q;

endmodule

// File: tb/tb_lcd1602_rdfuncmod.sv
// Directed bench for lcd1602_rdfuncmod with a cycle
// timeline model of EN, RS, oDone and read results.
module tb_lcd1602_rdfuncmod;

  localparam int TS   = 2;
  localparam int TE   = 25;
  localparam int TD   = 20;
  localparam int TH   = 23;
  localparam int MAXP = 4;
  localparam int PER  = TS + TE + TH + 1;

  logic CLOCK = 1'b0;
  logic RST_n = 1'b0;
  always #10 CLOCK = ~CLOCK;

  lcd1602_rdfuncmod_if bus ();

  wire       lcd_rs, lcd_rw, lcd_en;
  wire [7:0] lcd_d;

  logic [7:0] sched [8];
  int         nfall;
  logic [2:0] sidx;

  assign sidx  = (nfall > 7) ? 3'd7 : nfall[2:0];
  assign lcd_d = sched[sidx];

  lcd1602_rdfuncmod #(
    .T_SETUP   (TS),
    .T_ENH     (TE),
    .T_DSAMPLE (TD),
    .T_HOLD    (TH),
    .MAX_POLLS (MAXP)
  ) dut (
    .CLOCK      (CLOCK),
    .RST_n      (RST_n),
    .bus        (bus),
    .LCD1602_RS (lcd_rs),
    .LCD1602_RW (lcd_rw),
    .LCD1602_EN (lcd_en),
    .LCD1602_D  (lcd_d)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
  endtask

  bit         act_on = 1'b0;
  int         cyc, n_exp, done_c, abort_c;
  int         rises, seen_c;
  logic       exp_rs, exp_to, en_prev = 1'b0;
  logic [7:0] exp_d;

  function automatic int reads_for(input bit m,
                                   input bit r);
    if (!(m && !r)) return 1;
    for (int i = 0; i < MAXP; i++)
      if (!sched[i][7]) return i + 1;
    return MAXP;
  endfunction

  always @(negedge CLOCK) begin
    logic e_en;
    int   off;
    chk("rw", lcd_rw, 1);
    if (en_prev && !lcd_en) nfall++;
    if (!en_prev && lcd_en) rises++;
    en_prev = lcd_en;
    if (act_on) begin
      cyc++;
      if (cyc >= 1) begin
        off  = cyc - 3;
        e_en = (cyc >= 3) && (off / PER < n_exp) &&
               (off % PER < TE) && (cyc < abort_c);
        chk("en", lcd_en, e_en);
        chk("done", bus.oDone,
            (cyc == done_c) && (cyc < abort_c));
        chk("rs", lcd_rs, exp_rs);
        if (bus.oDone) seen_c = cyc;
        if (cyc == 2) chk("to_clr", bus.oTimeout, 0);
        if (cyc == done_c && cyc < abort_c) begin
          chk("data", bus.oData, exp_d);
          chk("tout", bus.oTimeout, exp_to);
        end
      end
    end
  end

  task automatic begin_txn(input bit m, input bit r);
    @(posedge CLOCK); #2;
    bus.iMode = m;
    bus.iRS   = r;
    bus.iCall = 1'b1;
    nfall   = 0;
    rises   = 0;
    seen_c  = 0;
    n_exp   = reads_for(m, r);
    exp_d   = sched[n_exp-1];
    exp_to  = m && !r && exp_d[7];
    exp_rs  = r;
    done_c  = TS + TE + TH + 3 + PER * (n_exp - 1);
    abort_c = 1 << 30;
    cyc     = -1;
    act_on  = 1'b1;
  endtask

  task automatic end_txn();
    #2 bus.iCall = 1'b0;
    repeat (3) @(posedge CLOCK);
    #2 act_on = 1'b0;
  endtask

  task automatic run(input bit m, input bit r,
                     input int extra);
    begin_txn(m, r);
    repeat (done_c + extra) @(posedge CLOCK);
    end_txn();
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 8; i++) sched[i] = v;
  endtask

  initial begin
    bus.iCall = 1'b0;
    bus.iMode = 1'b0;
    bus.iRS   = 1'b0;
    nfall     = 0;
    fill(8'h00);
    #5;
    chk("rst_en", lcd_en, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_done", bus.oDone, 0);
    chk("rst_to", bus.oTimeout, 0);
    chk("rst_data", bus.oData, 8'h00);
    repeat (3) @(posedge CLOCK);
    #2 RST_n = 1'b1;

    fill(8'h2A);
    run(1'b0, 1'b0, 2);
    chk("s_lat", seen_c, 53);
    chk("s_pulses", rises, 1);
    chk("s_data", bus.oData, 8'h2A);

    fill(8'h41);
    run(1'b1, 1'b1, 2);
    chk("d_pulses", rises, 1);
    chk("d_data", bus.oData, 8'h41);

    fill(8'h05);
    sched[0] = 8'h80;
    sched[1] = 8'h8A;
    sched[2] = 8'hC3;
    run(1'b1, 1'b0, 2);
    chk("p_pulses", rises, 4);
    chk("p_lat", seen_c, 53 + 3 * 51);
    chk("p_data", bus.oData, 8'h05);
    chk("p_tout", bus.oTimeout, 0);

    fill(8'hB1);
    run(1'b1, 1'b0, 200);
    chk("t_pulses", rises, 4);
    chk("t_tout", bus.oTimeout, 1);
    chk("t_bf", bus.oData[7], 1);

    fill(8'h12);
    run(1'b0, 1'b0, 2);
    chk("r_tout", bus.oTimeout, 0);
    chk("r_data", bus.oData, 8'h12);

    fill(8'h3C);
    begin_txn(1'b0, 1'b0);
    abort_c = 11;
    repeat (10) @(posedge CLOCK);
    #2 bus.iCall = 1'b0;
    repeat (70) @(posedge CLOCK);
    #2 act_on = 1'b0;
    chk("a_nodone", seen_c, 0);
    chk("a_keep", bus.oData, 8'h12);

    fill(8'h5A);
    begin_txn(1'b0, 1'b1);
    repeat (35) @(posedge CLOCK);
    #2 act_on = 1'b0;
    chk("h_data", bus.oData, 8'h5A);
    chk("h_rs", lcd_rs, 1);
    RST_n = 1'b0;
    #1;
    chk("h_en", lcd_en, 0);
    chk("h_rs0", lcd_rs, 0);
    chk("h_rw", lcd_rw, 1);
    chk("h_done", bus.oDone, 0);
    chk("h_to", bus.oTimeout, 0);
    chk("h_data0", bus.oData, 8'h00);
    bus.iCall = 1'b0;
    repeat (2) @(posedge CLOCK);
    #2 RST_n = 1'b1;
    repeat (2) @(posedge CLOCK);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
